// File: rtl/ws2812_pkg.sv
// ws2812_pkg
// Shared definitions for the WS2812 receiver: decoder state encoding, default
// timing constants in clk cycles, and the on-wire colour byte order.
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam int T1_MIN_DEF  = 29;
  localparam int T_HMAX_DEF  = 72;
  localparam int T_RESET_DEF = 2400;

  localparam int CNT_W      = 12;
  localparam int FRAME_BITS = 24;

  // Shadow is filled MSB-first, so the first byte on the wire (green) ends
  // up in the top lane.
  localparam int GREEN_LSB = 16;
  localparam int RED_LSB   = 8;
  localparam int BLUE_LSB  = 0;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  function automatic rgb_t unpack_grb(input logic [FRAME_BITS-1:0] shadow);
    rgb_t c;
    c.green = shadow[GREEN_LSB +: 8];
    c.red   = shadow[RED_LSB   +: 8];
    c.blue  = shadow[BLUE_LSB  +: 8];
    return c;
  endfunction

endpackage

// File: rtl/ws2812_edge_sync.sv
// ws2812_edge_sync
// Two-flop synchronizer for the asynchronous serial line plus a one-cycle
// rise/fall detector on the synchronized value.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   din    raw serial input
//   din_s  synchronized serial level
//   rise   one cycle high on the first cycle din_s is 1
//   fall   one cycle high on the first cycle din_s is 0
module ws2812_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic din_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      meta  <= din;
      din_s <= meta;
      din_d <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx
// WS2812 pixel receiver: decodes 24-bit GRB frames by high-pulse width,
// latches colour on a long low gap, and forwards everything after its own
// 24 bits to the next pixel.
// Parameters (clk cycles): T1_MIN shortest '1' pulse, T_HMAX stuck-high
// limit, T_RESET latch gap.
// Ports:
//   clk               system clock
//   reset             asynchronous active-low reset
//   din               raw serial input
//   dout              forwarded stream (din_s while passing, else 0)
//   red/green/blue    latched colour
//   valid             one-cycle pulse when the colour updates
//   frame_err         one-cycle pulse on a malformed frame
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int T1_MIN  = T1_MIN_DEF,
  parameter int T_HMAX  = T_HMAX_DEF,
  parameter int T_RESET = T_RESET_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       dout,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       valid,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] T1_MIN_C  = CNT_W'(T1_MIN);
  localparam logic [CNT_W-1:0] T_HMAX_C  = CNT_W'(T_HMAX);
  localparam logic [CNT_W-1:0] T_RESET_C = CNT_W'(T_RESET);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // Parking the low counter one past T_RESET makes the T_RESET value last
  // exactly one cycle, so each gap yields a single latch event.
  localparam logic [CNT_W-1:0] LOW_SAT   = (T_RESET >= 4095) ? CNT_MAX
                                                             : CNT_W'(T_RESET + 1);
  localparam logic [4:0]       BITS_C    = 5'(FRAME_BITS);

  logic din_s;
  logic rise;
  logic fall;

  ws2812_edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  state_t                state;
  logic [CNT_W-1:0]      cnt_low;
  logic [CNT_W-1:0]      cnt_high;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shadow;
  logic                  pass;
  rgb_t                  rgb_next;

  logic gap_hit;
  logic bit_val;
  logic stuck;

  // cnt_high holds the number of high cycles when the fall is seen.
  assign gap_hit  = (cnt_low == T_RESET_C);
  assign bit_val  = (cnt_high >= T1_MIN_C);
  assign stuck    = (cnt_high >= T_HMAX_C);
  assign rgb_next = unpack_grb(shadow);

  // Both sources are flops, so the forwarded stream keeps the synchronizer
  // latency and nothing more.
  assign dout = pass & din_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_low  <= '0;
      cnt_high <= '0;
    end else begin
      if (rise)
        cnt_low <= '0;
      else if (!din_s && cnt_low != LOW_SAT)
        cnt_low <= cnt_low + 1'b1;

      if (fall)
        cnt_high <= '0;
      else if (rise)
        cnt_high <= CNT_W'(1);
      else if (din_s && cnt_high != CNT_MAX)
        cnt_high <= cnt_high + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_SYNC;
      bit_cnt   <= '0;
      shadow    <= '0;
      pass      <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_SYNC: begin
          if (gap_hit) begin
            bit_cnt <= '0;
            pass    <= 1'b0;
            state   <= rise ? S_HIGH : S_LOW;
          end
        end
        S_LOW: begin
          if (gap_hit) begin
            if (bit_cnt == BITS_C) begin
              red   <= rgb_next.red;
              green <= rgb_next.green;
              blue  <= rgb_next.blue;
              valid <= 1'b1;
            end else if (bit_cnt != '0) begin
              frame_err <= 1'b1;
            end
            bit_cnt <= '0;
            pass    <= 1'b0;
          end
          if (rise)
            state <= S_HIGH;
        end
        S_HIGH: begin
          // A pulse of T_HMAX cycles is already an error, even if it ends
          // in the same cycle the limit is reached.
          if (stuck) begin
            frame_err <= 1'b1;
            shadow    <= '0;
            pass      <= 1'b0;
            bit_cnt   <= '0;
            state     <= S_SYNC;
          end else if (fall) begin
            if (bit_cnt != BITS_C) begin
              shadow  <= {shadow[FRAME_BITS-2:0], bit_val};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BITS_C - 5'd1)
                pass <= 1'b1;
            end
            state <= S_LOW;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int T0H    = 20;
  localparam int T1H    = 40;
  localparam int PERIOD = 62;
  localparam int GAP    = 2500;

  logic       clk;
  logic       reset;
  logic       din;
  logic       dout;
  logic [7:0] red, green, blue;
  logic       valid;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int val_cnt = 0;
  int err_cnt = 0;
  int hi_len = 0;
  int lat_n = 0;
  int lat_bad = 0;
  bit lat_win = 0;
  logic [1:0] din_hist = 2'b00;

  logic [23:0] exp_q[$];
  bit          fwd_q[$];

  ws2812_rx dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .dout      (dout),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .valid     (valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // din holds v for exactly n clk cycles
  task automatic drive(input logic v, input int n);
    @(posedge clk);
    #2 din = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic send_bit_len(input int hi);
    drive(1'b1, hi);
    drive(1'b0, PERIOD - hi);
  endtask

  task automatic send_bit(input logic b);
    send_bit_len(b ? T1H : T0H);
  endtask

  task automatic send_frame(input logic [23:0] grb);
    for (int i = 23; i >= 0; i--) send_bit(grb[i]);
  endtask

  task automatic send_gap();
    drive(1'b0, GAP);
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] v;

    din   = 1'b0;
    reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (valid) begin
          val_cnt++;
          if (exp_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
          else check("colour", {8'h0, green, red, blue}, {8'h0, exp_q.pop_front()});
        end
        if (frame_err) err_cnt++;
        if (dout) hi_len++;
        else if (hi_len != 0) begin
          fwd_q.push_back(hi_len >= T1_MIN_DEF);
          hi_len = 0;
        end
        if (lat_win) begin
          lat_n++;
          if (dout !== din_hist[1]) lat_bad++;
        end
        din_hist = {din_hist[0], din};
      end
    join_none

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_colour", {8'h0, green, red, blue}, 32'h0);
    check("rst_flags", {29'h0, valid, frame_err, dout}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    send_gap();

    // two-pixel chain: first pixel for us, second forwarded
    exp_q.push_back({8'd0, 8'd100, 8'd255});
    send_frame({8'd0, 8'd100, 8'd255});
    lat_win = 1'b1;
    send_frame(24'h5A3CC3);
    drive(1'b0, 10);
    lat_win = 1'b0;
    send_gap();
    check("t1_valid_cnt", val_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_fwd_len", fwd_q.size(), 24);
    w = '0;
    while (fwd_q.size() > 0) w = {w[22:0], fwd_q.pop_front()};
    check("t1_fwd_bits", {8'h0, w}, 32'h5A3CC3);
    check("t1_lat_bad", lat_bad, 0);
    check("t1_lat_seen", {31'h0, lat_n > 0}, 32'h1);

    // short frame
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    send_gap();
    check("t2_err_cnt", err_cnt, 1);
    check("t2_valid_cnt", val_cnt, 1);
    check("t2_colour_kept", {8'h0, green, red, blue}, 32'h0064FF);

    // pulse-width threshold
    v = 24'h123456;
    exp_q.push_back({2'b01, v[21:0]});
    send_bit_len(T1_MIN_DEF - 1);
    send_bit_len(T1_MIN_DEF);
    for (int i = 21; i >= 0; i--) send_bit(v[i]);
    send_gap();
    check("t3_valid_cnt", val_cnt, 2);
    check("t3_err_cnt", err_cnt, 1);

    // stuck high, then a frame without a preceding gap is ignored
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    drive(1'b1, 100);
    drive(1'b0, 200);
    check("t4_err_cnt", err_cnt, 2);
    send_frame(24'hABCDEF);
    send_gap();
    check("t4_no_valid", val_cnt, 2);
    check("t4_err_cnt2", err_cnt, 2);
    exp_q.push_back(24'h112233);
    send_frame(24'h112233);
    send_gap();
    check("t4_valid_cnt", val_cnt, 3);

    // reset mid-frame
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    din = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_rst_colour", {8'h0, green, red, blue}, 32'h0);
    check("t5_rst_flags", {29'h0, valid, frame_err, dout}, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    send_gap();
    exp_q.push_back(24'h00FF00);
    send_frame(24'h00FF00);
    send_gap();
    check("t5_valid_cnt", val_cnt, 4);
    check("t5_err_cnt", err_cnt, 2);
    check("t5_red", {24'h0, red}, 32'hFF);

    // back-to-back frames
    exp_q.push_back(24'hC0FFEE);
    send_frame(24'hC0FFEE);
    send_gap();
    exp_q.push_back(24'h0F1E2D);
    send_frame(24'h0F1E2D);
    send_gap();
    check("t6_valid_cnt", val_cnt, 6);
    check("t6_err_cnt", err_cnt, 2);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
